// File: rtl/sync_trial_sequencer_if.sv
// Control/status bundle between the tile's ui_in logic and the trial sequencer.
interface sync_trial_sequencer_if #(
  parameter int CNT_W  = 8,
  parameter int WAIT_W = 4
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  run_len;
  logic [WAIT_W-1:0] wait_cycles;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  trial_cnt;
  logic [CNT_W-1:0]  first_fail;

  modport master (
    output start, abort, run_len, wait_cycles,
    input  busy, done, err_cnt, trial_cnt, first_fail
  );

  modport slave (
    input  start, abort, run_len, wait_cycles,
    output busy, done, err_cnt, trial_cnt, first_fail
  );
endinterface

// File: rtl/sync_trial_sequencer.sv
// Launch/capture trial sequencer for a synchronizer-under-test; trial period is W+2 cycles.
// Optional first-failure capture is built when SYNC_TRIAL_FIRST_FAIL_EN is defined.
module sync_trial_sequencer #(
  parameter int CNT_W  = 8,
  parameter int WAIT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  dut_q,
  output logic                  dut_d,
  sync_trial_sequencer_if.slave ctl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state_q, state_d;
  logic              dut_d_q, dut_d_d;
  logic              exp_q, exp_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [WAIT_W-1:0] wlen_q, wlen_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  trial_q, trial_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  trial_inc;
  logic              mismatch;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
  logic [CNT_W-1:0]  ff_q, ff_d;
  logic              ff_flag_q, ff_flag_d;
`endif

  assign trial_inc = trial_q + CNT_ONE;
  assign mismatch  = (dut_q != exp_q);

  always_comb begin
    state_d = state_q;
    dut_d_d = dut_d_q;
    exp_d   = exp_q;
    wcnt_d  = wcnt_q;
    wlen_d  = wlen_q;
    len_d   = len_q;
    err_d   = err_q;
    trial_d = trial_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
    ff_d      = ff_q;
    ff_flag_d = ff_flag_q;
`endif
    if (ena) begin
      if (ctl.abort) begin
        // Abort beats start and leaves counters and dut_d untouched.
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (ctl.start) begin
              len_d   = ctl.run_len;
              wlen_d  = (ctl.wait_cycles == '0) ? WAIT_ONE : ctl.wait_cycles;
              err_d   = '0;
              trial_d = '0;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
              // All-ones is the "no failure this run" reading.
              ff_d      = CNT_MAX;
              ff_flag_d = 1'b0;
`endif
              state_d = S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            dut_d_d = ~dut_d_q;
            exp_d   = ~dut_d_q;
            wcnt_d  = wlen_q;
            state_d = S_WAIT;
          end
          S_WAIT: begin
            wcnt_d = wcnt_q - WAIT_ONE;
            if (wcnt_q <= WAIT_ONE) begin
              state_d = S_CHECK;
            end
          end
          S_CHECK: begin
            if (mismatch && (err_q != CNT_MAX)) begin
              err_d = err_q + CNT_ONE;
            end
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
            if (mismatch && !ff_flag_q) begin
              ff_d      = trial_q;
              ff_flag_d = 1'b1;
            end
`endif
            trial_d = trial_inc;
            // run_len of 0 wraps around to mean a full 2^CNT_W trials.
            state_d = (trial_inc == len_q) ? S_DONE : S_LAUNCH;
          end
          default: state_d = S_IDLE;
        endcase
      end
      busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dut_d_q <= 1'b0;
      exp_q   <= 1'b0;
      wcnt_q  <= '0;
      wlen_q  <= '0;
      len_q   <= '0;
      err_q   <= '0;
      trial_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
      ff_q      <= '0;
      ff_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dut_d_q <= dut_d_d;
      exp_q   <= exp_d;
      wcnt_q  <= wcnt_d;
      wlen_q  <= wlen_d;
      len_q   <= len_d;
      err_q   <= err_d;
      trial_q <= trial_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
      ff_q      <= ff_d;
      ff_flag_q <= ff_flag_d;
`endif
    end
  end

  assign dut_d         = dut_d_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.err_cnt   = err_q;
  assign ctl.trial_cnt = trial_q;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
  assign ctl.first_fail = ff_q;
`else
  assign ctl.first_fail = '0;
`endif

endmodule

// File: tb/tb_sync_trial_sequencer.sv
// Scoreboard bench for sync_trial_sequencer: a delay-line or stuck-at device under test,
// per-run expectations from a trial-level model, checked when done rises.
module tb_sync_trial_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic dut_q;
  logic dut_d;
  int   cyc = 0;

  sync_trial_sequencer_if #(.CNT_W(8), .WAIT_W(4)) ctl ();

  sync_trial_sequencer #(.CNT_W(8), .WAIT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .dut_q (dut_q),
    .dut_d (dut_d),
    .ctl   (ctl.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device under test: a delay line of lat flops frozen with the tile, or a stuck output.
  logic [2:0] chain = 3'b000;
  int         lat = 1;
  logic       stuck_en = 1'b0;
  logic       stuck_val = 1'b0;
  always @(posedge clk) if (ena) chain <= {chain[1:0], dut_d};
  assign dut_q = stuck_en ? stuck_val : chain[lat-1];

  typedef struct {
    int   trials;
    int   err;
    int   ff;
    logic dd;
    int   done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic mlvl = 1'b0;   // model's view of the dut_d level
  logic done_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Trial k drives level ~init for even k; a delay line shows it in time when lat <= W,
  // otherwise the sample still sees the previous trial's level.
  function automatic void model(input int n, input int w, input bit stk, input bit sv,
                                input int l, input logic init, output int fails, output int first);
    fails = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      logic lv, smp;
      lv  = ((k % 2) == 0) ? ~init : init;
      smp = stk ? sv : ((l <= w) ? lv : ~lv);
      if (smp != lv) begin
        fails++;
        if (first < 0) first = k;
      end
    end
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ctl.done && !done_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_cycle", cyc, mon_e.done_cyc);
          chk("trial_cnt", int'(ctl.trial_cnt), mon_e.trials);
          chk("err_cnt", int'(ctl.err_cnt), mon_e.err);
          chk("first_fail", int'(ctl.first_fail), mon_e.ff);
          chk("dut_d_at_done", int'(dut_d), int'(mon_e.dd));
          chk("busy_at_done", int'(ctl.busy), 0);
        end
      end
      done_prev = ctl.done;
    end
  end

  task automatic setup_dev(input bit stk, input bit sv, input int l);
    stuck_en  = stk;
    stuck_val = sv;
    lat       = l;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start(input int len, input int w_raw);
    ctl.run_len     = 8'(len);
    ctl.wait_cycles = 4'(w_raw);
    ctl.start       = 1'b1;
    @(negedge clk);
    ctl.start       = 1'b0;
  endtask

  task automatic do_run(input int len, input int w_raw, input bit stk, input bit sv,
                        input int l, input bit hold, input bit poke);
    exp_t e;
    int   n, w, fails, first, t;
    logic dd_hold;
    setup_dev(stk, sv, l);
    n = (len == 0) ? 256 : len;
    w = (w_raw == 0) ? 1 : w_raw;
    model(n, w, stk, sv, l, mlvl, fails, first);
    e.trials   = n % 256;
    e.err      = (fails > 255) ? 255 : fails;
`ifdef SYNC_TRIAL_FIRST_FAIL_EN
    e.ff       = (first < 0) ? 255 : first;
`else
    e.ff       = 0;
`endif
    e.dd       = mlvl ^ n[0];
    e.done_cyc = cyc + 1 + n * (w + 2) + (hold ? 5 : 0);
    sb_q.push_back(e);
    mlvl = e.dd;
    pulse_start(len, w_raw);
    if (hold) begin
      @(negedge clk);
      dd_hold = dut_d;
      ena = 1'b0;
      repeat (5) @(negedge clk);
      chk("ena_hold_dut_d", int'(dut_d), int'(dd_hold));
      chk("ena_hold_busy", int'(ctl.busy), 1);
      ena = 1'b1;
    end else if (poke) begin
      @(negedge clk);
    end
    if (poke) begin
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
    end
    t = 0;
    while (!ctl.done && t < n * (w + 2) + 50) begin
      @(negedge clk);
      t++;
    end
    if (!ctl.done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done still low after %0d cycles (len %0d wait %0d)", t, len, w_raw);
    end
  endtask

  task automatic do_abort(input int w_raw, input bit stk, input bit sv, input int l);
    int w, fails, first;
    setup_dev(stk, sv, l);
    w = (w_raw == 0) ? 1 : w_raw;
    model(4, w, stk, sv, l, mlvl, fails, first);
    pulse_start(10, w_raw);
    repeat (4 * (w + 2) + 1) @(negedge clk);
    ctl.abort = 1'b1;
    @(negedge clk);
    ctl.abort = 1'b0;
    chk("abort_busy", int'(ctl.busy), 0);
    chk("abort_done", int'(ctl.done), 0);
    chk("abort_trial_cnt", int'(ctl.trial_cnt), 4);
    chk("abort_err_cnt", int'(ctl.err_cnt), fails);
    mlvl = ~mlvl;  // five launches happened before the abort
    chk("abort_dut_d", int'(dut_d), int'(mlvl));
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", int'(ctl.busy), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n           = 1'b0;
    ena             = 1'b1;
    ctl.start       = 1'b0;
    ctl.abort       = 1'b0;
    ctl.run_len     = '0;
    ctl.wait_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(ctl.busy), 0);
    chk("rst_done", int'(ctl.done), 0);
    chk("rst_err_cnt", int'(ctl.err_cnt), 0);
    chk("rst_trial_cnt", int'(ctl.trial_cnt), 0);
    chk("rst_first_fail", int'(ctl.first_fail), 0);
    chk("rst_dut_d", int'(dut_d), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(10, 1, 1'b0, 1'b0, 1, 1'b0, 1'b0);   // fast device, all pass
    do_run(10, 1, 1'b0, 1'b0, 2, 1'b0, 1'b0);   // device slower than the wait
    do_run(10, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0);   // wait long enough again
    do_run(0, 0, 1'b1, 1'b0, 1, 1'b0, 1'b0);    // stuck low, 256 trials
    do_run(0, 0, 1'b0, 1'b0, 2, 1'b0, 1'b0);    // 256 failures saturate
    do_run(8, 3, 1'b0, 1'b0, 1, 1'b1, 1'b1);    // ena freeze plus start while busy

    do_abort(2, 1'b0, 1'b0, 3);
    do_run(6, 2, 1'b0, 1'b0, 1, 1'b0, 1'b0);    // fresh start after abort

    // abort and start together in DONE and in IDLE
    ctl.start = 1'b1;
    ctl.abort = 1'b1;
    @(negedge clk);
    chk("abort_start_done_done", int'(ctl.done), 0);
    chk("abort_start_done_busy", int'(ctl.busy), 0);
    chk("abort_start_done_trial", int'(ctl.trial_cnt), 6);
    @(negedge clk);
    ctl.start = 1'b0;
    ctl.abort = 1'b0;
    chk("abort_start_idle_busy", int'(ctl.busy), 0);

    // reset during CHECK with the tile disabled
    setup_dev(1'b0, 1'b0, 1);
    pulse_start(5, 2);
    repeat (3) @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(ctl.busy), 0);
    chk("midrst_done", int'(ctl.done), 0);
    chk("midrst_trial_cnt", int'(ctl.trial_cnt), 0);
    chk("midrst_err_cnt", int'(ctl.err_cnt), 0);
    chk("midrst_first_fail", int'(ctl.first_fail), 0);
    chk("midrst_dut_d", int'(dut_d), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    mlvl  = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_run(int'($urandom_range(1, 20)), int'($urandom_range(0, 4)),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
